// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver; new data is applied only at frame boundaries.
// Define SEG_LZ_SUPPRESS_EN to blank leading zeros (digit 0 is always shown).
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYC       = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_en,
  output logic                    load_ack,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_dig_q, disp_dig_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_v_q, pend_v_d;
  logic                    ack_q, ack_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;

  logic                    slot_end, frame_end, sel_on, cur_dp;
  logic [3:0]              cur_nib;
  logic [6:0]              seg_al;
  logic [NUM_DIGITS-1:0]   lz_mask, sel_ah;
`ifdef SEG_LZ_SUPPRESS_EN
  logic                    zero_run;
`endif

  // Patterns are held in active-low form, bit 6 = g down to bit 0 = a.
  function automatic logic [6:0] decode_al(input logic [3:0] nib);
    case (nib)
      4'd0:    decode_al = 7'b1000000;
      4'd1:    decode_al = 7'b1111001;
      4'd2:    decode_al = 7'b0100100;
      4'd3:    decode_al = 7'b0110000;
      4'd4:    decode_al = 7'b0011001;
      4'd5:    decode_al = 7'b0010010;
      4'd6:    decode_al = 7'b0000010;
      4'd7:    decode_al = 7'b1111000;
      4'd8:    decode_al = 7'b0000000;
      4'd9:    decode_al = 7'b0010000;
      default: decode_al = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    slot_end   = (cnt_q == CNT_LAST);
    frame_end  = slot_end && (idx_q == IDX_LAST);
    cnt_d      = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    disp_dig_d = disp_dig_q;
    disp_dp_d  = disp_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_v_d   = pend_v_q;
    ack_d      = 1'b0;
    // A load in the boundary cycle bypasses the pending register entirely.
    if (frame_end) begin
      if (load) begin
        disp_dig_d = digits;
        disp_dp_d  = dp_in;
        pend_v_d   = 1'b0;
        ack_d      = 1'b1;
      end else if (pend_v_q) begin
        disp_dig_d = pend_dig_q;
        disp_dp_d  = pend_dp_q;
        pend_v_d   = 1'b0;
        ack_d      = 1'b1;
      end
    end else if (load) begin
      pend_dig_d = digits;
      pend_dp_d  = dp_in;
      pend_v_d   = 1'b1;
    end
  end

  always_comb begin
    cur_nib = 4'd0;
    cur_dp  = 1'b0;
    lz_mask = '0;
    sel_ah  = '0;
`ifdef SEG_LZ_SUPPRESS_EN
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (disp_dig_q[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_run;
    end
`endif
    sel_on = (cnt_q >= CNT_DEAD) && !blank_en;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = disp_dig_q[4*i +: 4];
        cur_dp    = disp_dp_q[i] & 1'b1;
        sel_ah[i] = sel_on;
        if (lz_mask[i]) cur_nib = cur_nib;
      end
    end
    seg_al = decode_al(cur_nib);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((idx_q == IDX_W'(i)) && lz_mask[i]) seg_al = 7'h7F;
    end
    seg_d   = (SEG_ACTIVE_LOW != 0) ? seg_al : ~seg_al;
    dp_d    = (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
    sel_d   = (SEL_ACTIVE_LOW != 0) ? ~sel_ah : sel_ah;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_dig_q <= '0;
      disp_dp_q  <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_v_q   <= 1'b0;
      ack_q      <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      sel_q      <= SEL_OFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_dig_q <= disp_dig_d;
      disp_dp_q  <= disp_dp_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_v_q   <= pend_v_d;
      ack_q      <= ack_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
    end
  end

  assign load_ack = ack_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign dig_sel  = sel_q;

endmodule
